// File: rtl/tmds_encoder_multi.sv
// NUM_CH-lane TMDS encoder: DC-balanced 8b/10b video, 2-bit control symbols, optional TERC4.
// Define TMDS_TERC4_EN to encode terc_in on mode 2'b10; otherwise that mode emits control symbols.
module tmds_encoder_multi #(
  parameter int NUM_CH = 3
) (
  input  logic                 clk_in,
  input  logic                 rst_in_n,
  input  logic                 valid_in,
  input  logic [1:0]           mode_in,
  input  logic [8*NUM_CH-1:0]  data_in,
  input  logic [2*NUM_CH-1:0]  ctrl_in,
  input  logic [4*NUM_CH-1:0]  terc_in,
  output logic [10*NUM_CH-1:0] tmds_out,
  output logic                 valid_out
);

  typedef enum logic [1:0] {
    MODE_CTRL  = 2'b00,
    MODE_VIDEO = 2'b01,
    MODE_TERC  = 2'b10,
    MODE_RSVD  = 2'b11
  } mode_e;

  mode_e s1_mode;
  logic  s1_valid;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  // Transition-minimising stage: XNOR chain when the byte is ones-heavy, XOR chain otherwise.
  function automatic logic [8:0] transition_min(input logic [7:0] d);
    logic [3:0] n1;
    logic       use_xnor;
    logic [8:0] q;
    n1       = popcount8(d);
    use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
    q        = '0;
    q[0]     = d[0];
    for (int i = 1; i < 8; i++) q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    q[8]     = ~use_xnor;
    return q;
  endfunction

  function automatic logic [9:0] ctrl_code(input logic [1:0] c);
    logic [9:0] s;
    case (c)
      2'b00:   s = 10'h354;
      2'b01:   s = 10'h0AB;
      2'b10:   s = 10'h154;
      default: s = 10'h2AB;
    endcase
    return s;
  endfunction

`ifdef TMDS_TERC4_EN
  function automatic logic [9:0] terc_code(input logic [3:0] t);
    logic [9:0] s;
    case (t)
      4'h0: s = 10'h29C;  4'h1: s = 10'h263;  4'h2: s = 10'h2E4;  4'h3: s = 10'h2E2;
      4'h4: s = 10'h171;  4'h5: s = 10'h11E;  4'h6: s = 10'h18E;  4'h7: s = 10'h13C;
      4'h8: s = 10'h2CC;  4'h9: s = 10'h139;  4'hA: s = 10'h19C;  4'hB: s = 10'h2C7;
      4'hC: s = 10'h28E;  4'hD: s = 10'h271;  4'hE: s = 10'h163;  default: s = 10'h2C3;
    endcase
    return s;
  endfunction
`else
  logic unused_terc;
  assign unused_terc = ^terc_in;
`endif

  // Shared valid/mode pipeline; bubbles flow through as s1_valid=0 and never touch lane state.
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      s1_valid  <= 1'b0;
      s1_mode   <= MODE_CTRL;
      valid_out <= 1'b0;
    end else begin
      s1_valid  <= valid_in;
      s1_mode   <= mode_e'(mode_in);
      valid_out <= s1_valid;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    logic [8:0]        qm_q;
    logic [1:0]        ctrl_q;
    logic [9:0]        sym_q, sym_nxt;
    logic signed [4:0] cnt_q, cnt_nxt;
    logic signed [4:0] n1q, n0q, diff;
`ifdef TMDS_TERC4_EN
    logic [3:0]        terc_q;
`endif

    always_ff @(posedge clk_in or negedge rst_in_n) begin
      if (!rst_in_n) begin
        qm_q   <= '0;
        ctrl_q <= '0;
`ifdef TMDS_TERC4_EN
        terc_q <= '0;
`endif
      end else begin
        qm_q   <= transition_min(data_in[8*c +: 8]);
        ctrl_q <= ctrl_in[2*c +: 2];
`ifdef TMDS_TERC4_EN
        terc_q <= terc_in[4*c +: 4];
`endif
      end
    end

    // DC-balance decision: invert the payload whenever that pulls the running disparity toward zero.
    always_comb begin
      n1q     = signed'({1'b0, popcount8(qm_q[7:0])});
      n0q     = 5'sd8 - n1q;
      diff    = n1q - n0q;
      sym_nxt = sym_q;
      cnt_nxt = cnt_q;
      case (s1_mode)
        MODE_VIDEO: begin
          if ((cnt_q == 5'sd0) || (n1q == n0q)) begin
            sym_nxt = {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
            cnt_nxt = qm_q[8] ? (cnt_q + diff) : (cnt_q - diff);
          end else if (((cnt_q > 5'sd0) && (n1q > n0q)) || ((cnt_q < 5'sd0) && (n0q > n1q))) begin
            sym_nxt = {1'b1, qm_q[8], ~qm_q[7:0]};
            cnt_nxt = cnt_q + (qm_q[8] ? 5'sd2 : 5'sd0) - diff;
          end else begin
            sym_nxt = {1'b0, qm_q[8], qm_q[7:0]};
            cnt_nxt = cnt_q + diff - (qm_q[8] ? 5'sd0 : 5'sd2);
          end
        end
`ifdef TMDS_TERC4_EN
        MODE_TERC: begin
          sym_nxt = terc_code(terc_q);
          cnt_nxt = 5'sd0;
        end
`endif
        default: begin
          sym_nxt = ctrl_code(ctrl_q);
          cnt_nxt = 5'sd0;
        end
      endcase
    end

    always_ff @(posedge clk_in or negedge rst_in_n) begin
      if (!rst_in_n) begin
        sym_q <= '0;
        cnt_q <= 5'sd0;
      end else if (s1_valid) begin
        sym_q <= sym_nxt;
        cnt_q <= cnt_nxt;
      end
    end

    assign tmds_out[10*c +: 10] = sym_q;
  end

endmodule

// File: tb/tb_tmds_encoder_multi.sv
// Self-checking bench for tmds_encoder_multi: per-lane reference model feeding a scoreboard queue.
module tb_tmds_encoder_multi;
  localparam int NUM_CH = 3;

  logic                 clk_in = 1'b0;
  logic                 rst_in_n;
  logic                 valid_in;
  logic [1:0]           mode_in;
  logic [8*NUM_CH-1:0]  data_in;
  logic [2*NUM_CH-1:0]  ctrl_in;
  logic [4*NUM_CH-1:0]  terc_in;
  logic [10*NUM_CH-1:0] tmds_out;
  logic                 valid_out;

  typedef struct packed {
    logic [10*NUM_CH-1:0] sym;
    logic [1:0]           mode;
    logic [8*NUM_CH-1:0]  data;
  } exp_t;

  exp_t                 sb[$];
  int                   model_cnt[NUM_CH];
  int                   tests_run = 0;
  int                   tests_failed = 0;
  logic [1:0]           v_hist;
  logic [10*NUM_CH-1:0] last_sym;

  tmds_encoder_multi #(.NUM_CH(NUM_CH)) dut (
    .clk_in(clk_in), .rst_in_n(rst_in_n), .valid_in(valid_in), .mode_in(mode_in),
    .data_in(data_in), .ctrl_in(ctrl_in), .terc_in(terc_in),
    .tmds_out(tmds_out), .valid_out(valid_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] want);
    tests_run++;
    if (obs !== want) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, want);
    end
  endtask

  function automatic logic [9:0] ctrlModel(input logic [1:0] c);
    logic [9:0] tbl [4];
    tbl = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
    return tbl[c];
  endfunction

  function automatic logic [9:0] tercModel(input logic [3:0] t);
    logic [9:0] tbl [16];
    tbl = '{10'h29C, 10'h263, 10'h2E4, 10'h2E2, 10'h171, 10'h11E, 10'h18E, 10'h13C,
            10'h2CC, 10'h139, 10'h19C, 10'h2C7, 10'h28E, 10'h271, 10'h163, 10'h2C3};
    return tbl[t];
  endfunction

  function automatic logic [9:0] videoModel(input int lane, input logic [7:0] d);
    int         ones, n1, n0, c;
    logic       inv;
    logic [8:0] qm;
    logic [9:0] s;
    ones  = $countones(d);
    inv   = (ones > 4) || (ones == 4 && !d[0]);
    qm    = '0;
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = inv ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = !inv;
    n1    = $countones(qm[7:0]);
    n0    = 8 - n1;
    c     = model_cnt[lane];
    if (c == 0 || n1 == n0) begin
      s = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      c = c + (qm[8] ? (n1 - n0) : (n0 - n1));
    end else if ((c > 0 && n1 > n0) || (c < 0 && n0 > n1)) begin
      s = {1'b1, qm[8], ~qm[7:0]};
      c = c + (qm[8] ? 2 : 0) + n0 - n1;
    end else begin
      s = {1'b0, qm[8], qm[7:0]};
      c = c + n1 - n0 - (qm[8] ? 0 : 2);
    end
    model_cnt[lane] = c;
    return s;
  endfunction

  function automatic logic [10*NUM_CH-1:0] symModel(input logic [1:0] m, input logic [8*NUM_CH-1:0] d,
                                                    input logic [2*NUM_CH-1:0] c, input logic [4*NUM_CH-1:0] t);
    logic [10*NUM_CH-1:0] s;
    s = '0;
    for (int l = 0; l < NUM_CH; l++) begin
      if (m == 2'b01) s[10*l +: 10] = videoModel(l, d[8*l +: 8]);
`ifdef TMDS_TERC4_EN
      else if (m == 2'b10) begin
        s[10*l +: 10] = tercModel(t[4*l +: 4]);
        model_cnt[l]  = 0;
      end
`endif
      else begin
        s[10*l +: 10] = ctrlModel(c[2*l +: 2]);
        model_cnt[l]  = 0;
      end
    end
    return s;
  endfunction

  function automatic logic [7:0] decodeLane(input logic [9:0] s);
    logic [7:0] qm, d;
    qm   = s[9] ? ~s[7:0] : s[7:0];
    d    = '0;
    d[0] = qm[0];
    for (int i = 1; i < 8; i++) d[i] = s[8] ? (qm[i] ^ qm[i-1]) : ~(qm[i] ^ qm[i-1]);
    return d;
  endfunction

  // One clock of stimulus; the symbol driven now is expected on valid_out two edges later.
  task automatic applyStimulus(input logic v, input logic [1:0] m, input logic [8*NUM_CH-1:0] d,
                               input logic [2*NUM_CH-1:0] c, input logic [4*NUM_CH-1:0] t,
                               input logic use_exp, input logic [10*NUM_CH-1:0] exp_sym);
    logic [10*NUM_CH-1:0] s;
    exp_t                 e;
    valid_in = v;
    mode_in  = m;
    data_in  = d;
    ctrl_in  = c;
    terc_in  = t;
    if (v) begin
      s = symModel(m, d, c, t);
      if (use_exp) s = exp_sym;
      sb.push_back({s, m, d});
    end
    @(posedge clk_in);
    v_hist = {v_hist[0], v};
    #1;
    checkOutput("valid_out", 32'(valid_out), 32'(v_hist[1]));
    if (valid_out) begin
      if (sb.size() == 0) checkOutput("valid_out_spurious", 32'(valid_out), 32'd0);
      else begin
        e = sb.pop_front();
        checkOutput("tmds_out", 32'(tmds_out), 32'(e.sym));
        last_sym = e.sym;
        if (e.mode == 2'b01)
          for (int l = 0; l < NUM_CH; l++)
            checkOutput("decode", 32'(decodeLane(tmds_out[10*l +: 10])), 32'(e.data[8*l +: 8]));
      end
    end else begin
      checkOutput("tmds_hold", 32'(tmds_out), 32'(last_sym));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 2'b01, 24'($urandom()), 6'($urandom()), 12'($urandom()), 1'b0, '0);
  endtask

  // Async reset asserted mid-cycle with random inputs; released away from the clock edge.
  task automatic resetDut();
    valid_in = 1'($urandom());
    mode_in  = 2'($urandom());
    data_in  = 24'($urandom());
    ctrl_in  = 6'($urandom());
    terc_in  = 12'($urandom());
    #2 rst_in_n = 1'b0;
    #1;
    checkOutput("rst_async_tmds", 32'(tmds_out), 32'd0);
    checkOutput("rst_async_valid", 32'(valid_out), 32'd0);
    sb.delete();
    for (int l = 0; l < NUM_CH; l++) model_cnt[l] = 0;
    v_hist   = '0;
    last_sym = '0;
    repeat (2) @(posedge clk_in);
    #1;
    checkOutput("rst_hold_tmds", 32'(tmds_out), 32'd0);
    checkOutput("rst_hold_valid", 32'(valid_out), 32'd0);
    rst_in_n = 1'b1;
    idle(2);
  endtask

  initial begin
    rst_in_n = 1'b1;
    valid_in = 1'b0;
    mode_in  = '0;
    data_in  = '0;
    ctrl_in  = '0;
    terc_in  = '0;
    v_hist   = '0;
    last_sym = '0;
    #2;
    resetDut();

    // Control symbols, including reserved mode 11.
    applyStimulus(1, 2'b00, 24'hA5A5A5, 6'b10_01_00, 12'h000, 1, {10'h154, 10'h0AB, 10'h354});
    applyStimulus(1, 2'b00, 24'h123456, 6'b11_11_11, 12'h000, 1, {3{10'h2AB}});
    applyStimulus(1, 2'b11, 24'h00FF00, 6'b00_00_00, 12'h000, 1, {3{10'h354}});

    // DC balance from cleared disparity.
    applyStimulus(1, 2'b01, 24'h000000, 6'b00_00_00, 12'h000, 1, {3{10'h100}});
    applyStimulus(1, 2'b01, 24'h000000, 6'b00_00_00, 12'h000, 1, {3{10'h3FF}});
    applyStimulus(1, 2'b00, 24'h000000, 6'b00_00_00, 12'h000, 1, {3{10'h354}});
    applyStimulus(1, 2'b01, 24'hFFFFFF, 6'b00_00_00, 12'h000, 1, {3{10'h200}});
    applyStimulus(1, 2'b00, 24'h000000, 6'b00_00_00, 12'h000, 1, {3{10'h354}});

    // Bubbles must not disturb disparity.
    applyStimulus(1, 2'b01, 24'h000000, 6'b00_00_00, 12'h000, 1, {3{10'h100}});
    idle(3);
    applyStimulus(1, 2'b01, 24'h000000, 6'b00_00_00, 12'h000, 1, {3{10'h3FF}});

    // Control symbol in the middle of video clears disparity.
    applyStimulus(1, 2'b01, 24'h5A3C00, 6'b00_00_00, 12'h000, 0, '0);
    applyStimulus(1, 2'b00, 24'h000000, 6'b00_00_00, 12'h000, 1, {3{10'h354}});
    applyStimulus(1, 2'b01, 24'h000000, 6'b00_00_00, 12'h000, 1, {3{10'h100}});

    // Island mode: TERC4 codes when enabled, else control codes of ctrl_in.
`ifdef TMDS_TERC4_EN
    applyStimulus(1, 2'b10, 24'h000000, 6'b11_01_00, {4'hF, 4'h5, 4'h0}, 1, {10'h2C3, 10'h11E, 10'h29C});
`else
    applyStimulus(1, 2'b10, 24'h000000, 6'b11_01_00, {4'hF, 4'h5, 4'h0}, 1, {10'h2AB, 10'h0AB, 10'h354});
`endif
    applyStimulus(1, 2'b01, 24'h000000, 6'b00_00_00, 12'h000, 1, {3{10'h100}});

    // Reset mid-stream discards in-flight symbols and restarts disparity.
    applyStimulus(1, 2'b01, 24'h0F3377, 6'b00_00_00, 12'h000, 0, '0);
    applyStimulus(1, 2'b01, 24'hC0FFEE, 6'b00_00_00, 12'h000, 0, '0);
    resetDut();
    applyStimulus(1, 2'b01, 24'h000000, 6'b00_00_00, 12'h000, 1, {3{10'h100}});
    idle(2);

    for (int i = 0; i < 10000; i++)
      applyStimulus(1'($urandom_range(0, 3) != 0), 2'($urandom()), 24'($urandom()),
                    6'($urandom()), 12'($urandom()), 1'b0, '0);
    idle(3);
    checkOutput("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
